// File: rtl/jesd_tx_link_fsm.sv
// JESD204B TX link-layer sequencer: CGS, ILAS and user data driven by SYNC~ and LMFC.
// Optional macro JESD_TX_CHAR_REPLACE_EN enables end-of-frame character replacement in DATA.
module jesd_tx_link_fsm #(
   parameter int F            = 1,
   parameter int K            = 32,
   parameter int ILAS_MF      = 4,
   parameter int SYNC_REQ_CYC = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_sync_n,
   input  logic         i_lmfc_edge,
   input  logic [111:0] i_cfg,
   input  logic [7:0]   i_data,
   output logic         o_data_ready,
   output logic [7:0]   o_char,
   output logic         o_k,
   output logic         o_rd_en,
   output logic [1:0]   o_state,
   output logic [7:0]   o_sync_err_cnt
);

   localparam int FK = F * K;
   localparam int OW = $clog2(FK);
   localparam int MW = $clog2(ILAS_MF);
   localparam logic [OW-1:0] OCT_LAST = OW'(FK - 1);
   localparam logic [MW-1:0] MF_LAST  = MW'(ILAS_MF - 1);

   localparam logic [7:0] K28_0 = 8'h1C;
   localparam logic [7:0] K28_3 = 8'h7C;
   localparam logic [7:0] K28_4 = 8'h9C;
   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_7 = 8'hFC;

   typedef enum logic [1:0] {
      ST_CGS       = 2'd0,
      ST_ILAS_WAIT = 2'd1,
      ST_ILAS      = 2'd2,
      ST_DATA      = 2'd3
   } state_t;

   state_t          state_reg;
   logic [OW-1:0]   oct_reg, oct_next;
   logic [MW-1:0]   mf_reg, mf_cur;
   logic [3:0]      low_run_reg, low_run_next;
   logic [7:0]      char_reg, err_cnt_reg;
   logic            k_reg, rd_en_reg, ready_reg;
   logic            resync, pulse_end, ilas_done, data_emit;
   logic [7:0]      ilas_char, data_char;
   logic            ilas_k, data_k;
   logic [3:0]      cfg_idx;
   logic [7:0]      cfg_oct [16];

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_cfg
         if (gi < 14) begin : g_used
            assign cfg_oct[gi] = i_cfg[8*gi +: 8];
         end else begin : g_pad
            assign cfg_oct[gi] = 8'h00;
         end
      end
   endgenerate

   // oct_next is the multiframe index of the octet launched at this edge.
   always_comb begin
      oct_next     = (i_lmfc_edge || oct_reg == OCT_LAST) ? '0 : oct_reg + OW'(1);
      low_run_next = i_sync_n ? 4'd0 : ((low_run_reg == 4'hF) ? 4'hF : low_run_reg + 4'd1);
      resync       = !i_sync_n && (({1'b0, low_run_reg} + 5'd1) == 5'(SYNC_REQ_CYC));
      pulse_end    = i_sync_n && (low_run_reg != 4'd0) && (low_run_reg < 4'(SYNC_REQ_CYC));
      ilas_done    = (oct_reg == OCT_LAST) && (mf_reg == MF_LAST);
      mf_cur       = (oct_reg == OCT_LAST) ? mf_reg + MW'(1) : mf_reg;
      data_emit    = !resync && (state_reg == ST_DATA || (state_reg == ST_ILAS && ilas_done));
      cfg_idx      = 4'(oct_next - OW'(2));

      ilas_char = 8'(oct_next);
      ilas_k    = 1'b0;
      if (oct_next == '0) begin
         ilas_char = K28_0;
         ilas_k    = 1'b1;
      end else if (oct_next == OCT_LAST) begin
         ilas_char = K28_3;
         ilas_k    = 1'b1;
      end else if (mf_cur == MW'(1)) begin
         if (oct_next == OW'(1)) begin
            ilas_char = K28_4;
            ilas_k    = 1'b1;
         end else if (oct_next <= OW'(15)) begin
            ilas_char = cfg_oct[cfg_idx];
         end
      end
   end

`ifdef JESD_TX_CHAR_REPLACE_EN
   localparam int FW = (F > 1) ? $clog2(F) : 1;
   localparam logic [FW-1:0] FPOS_LAST = FW'(F - 1);

   logic [FW-1:0] fpos_reg, fpos_next;
   logic [7:0]    prev_reg;
   logic          have_prev_reg, frame_last, repl;

   always_comb begin
      fpos_next  = (oct_next == '0 || fpos_reg == FPOS_LAST) ? '0 : fpos_reg + FW'(1);
      frame_last = (fpos_next == FPOS_LAST);
      repl       = have_prev_reg && frame_last && (i_data == prev_reg);
      data_char  = repl ? ((oct_next == OCT_LAST) ? K28_3 : K28_7) : i_data;
      data_k     = repl;
   end

   // The comparison history holds the original octet, never the substituted K-character.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpos_reg      <= '0;
         prev_reg      <= 8'h00;
         have_prev_reg <= 1'b0;
      end else begin
         fpos_reg <= fpos_next;
         if (data_emit) begin
            if (frame_last) begin
               prev_reg      <= i_data;
               have_prev_reg <= 1'b1;
            end
         end else begin
            have_prev_reg <= 1'b0;
         end
      end
   end
`else
   always_comb begin
      data_char = i_data;
      data_k    = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_CGS;
         oct_reg     <= '0;
         mf_reg      <= '0;
         low_run_reg <= 4'd0;
         char_reg    <= K28_5;
         k_reg       <= 1'b1;
         rd_en_reg   <= 1'b0;
         ready_reg   <= 1'b0;
         err_cnt_reg <= 8'd0;
      end else begin
         rd_en_reg   <= 1'b1;
         oct_reg     <= oct_next;
         low_run_reg <= low_run_next;
         case (state_reg)
            ST_CGS: begin
               char_reg  <= K28_5;
               k_reg     <= 1'b1;
               ready_reg <= 1'b0;
               if (i_sync_n) state_reg <= ST_ILAS_WAIT;
            end
            ST_ILAS_WAIT: begin
               char_reg  <= K28_5;
               k_reg     <= 1'b1;
               ready_reg <= 1'b0;
               if (!i_sync_n) begin
                  state_reg <= ST_CGS;
               end else if (i_lmfc_edge) begin
                  state_reg <= ST_ILAS;
                  mf_reg    <= '0;
                  char_reg  <= K28_0;
               end
            end
            ST_ILAS: begin
               if (resync) begin
                  state_reg <= ST_CGS;
                  char_reg  <= K28_5;
                  k_reg     <= 1'b1;
                  ready_reg <= 1'b0;
               end else if (ilas_done) begin
                  state_reg <= ST_DATA;
                  char_reg  <= data_char;
                  k_reg     <= data_k;
                  ready_reg <= 1'b1;
               end else begin
                  mf_reg   <= mf_cur;
                  char_reg <= ilas_char;
                  k_reg    <= ilas_k;
               end
            end
            default: begin
               if (resync) begin
                  state_reg <= ST_CGS;
                  char_reg  <= K28_5;
                  k_reg     <= 1'b1;
                  ready_reg <= 1'b0;
               end else begin
                  char_reg  <= data_char;
                  k_reg     <= data_k;
                  ready_reg <= 1'b1;
                  if (pulse_end && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
               end
            end
         endcase
      end
   end

   assign o_state        = state_reg;
   assign o_char         = char_reg;
   assign o_k            = k_reg;
   assign o_rd_en        = rd_en_reg;
   assign o_data_ready   = ready_reg;
   assign o_sync_err_cnt = err_cnt_reg;

endmodule
